spi_frame_rx: RTL and testbench

Parametrised SPI peripheral frame receiver, the successor to the fixed 1+7+8-bit deserializer. It sits between the chip's SPI pins and the register file, and converts CS-delimited SPI frames into register-write strobes. It supports configurable address and data widths and all four SPI modes. It adds burst transfers with address auto-increment and frame-error reporting. All state is in the `clk` domain; the SPI pins are asynchronous inputs.

---
 rtl/spi_frame_rx_if.sv | 28 ++
 rtl/spi_frame_rx.sv | 156 +++++++++++++++
 tb/tb_spi_frame_rx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_rx_if.sv
// SPI frame receiver bus bundle.
// Pin side : sclk, copi, n_cs (driven by the SPI controller, asynchronous to clk).
// Reg side : read_write, addr, data, valid, frame_err, busy (driven by the receiver).
// master modport = SPI controller / register-file view, slave modport = receiver.
interface spi_frame_rx_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              copi;
    logic              n_cs;
    logic              read_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output sclk, copi, n_cs,
        input  read_write, addr, data, valid, frame_err, busy
    );

    modport slave (
        input  sclk, copi, n_cs,
        output read_write, addr, data, valid, frame_err, busy
    );
endinterface

// File: rtl/spi_frame_rx.sv
// CS-delimited SPI frame receiver producing register-write strobes.
// A frame is R/W bit, ADDR_W address bits, then one (or, in burst mode, many)
// DATA_W data words, all MSB-first. Each completed word pulses valid with
// read_write/addr/data; addr auto-increments per word in burst mode.
// Ports:
//   clk  - system clock, sole clock of the block
//   rst  - asynchronous active-high reset
//   bus  - spi_frame_rx_if.slave: SPI pins in, decoded word/strobes out
module spi_frame_rx #(
    parameter int CDC_LEN  = 2,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0,
    parameter bit BURST_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    spi_frame_rx_if.slave bus
);
    localparam int MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W    = $clog2(MAX_BITS);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [2:0] {WAIT_CS, IDLE, HDR, DATA, OVF} state_t;

    logic [CDC_LEN:0]   sclk_sync;
    logic [CDC_LEN-1:0] copi_sync;
    logic [CDC_LEN-1:0] ncs_sync;
    // Marks when the synchroniser holds real pin samples rather than reset values.
    logic [CDC_LEN-1:0] sync_primed;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic              got_word;
    logic [ADDR_W:0]   hdr_sr;
    logic [DATA_W-1:0] data_sr;
    logic              read_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              frame_err_q;

    logic              sclk_new, sclk_old, copi_s, ncs_s, sample;
    logic [ADDR_W:0]   hdr_next;
    logic [DATA_W-1:0] data_next;
    logic              frame_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync   <= {(CDC_LEN + 1){CPOL}};
            copi_sync   <= '0;
            ncs_sync    <= '1;
            sync_primed <= '0;
        end else begin
            sclk_sync   <= {sclk_sync[CDC_LEN-1:0], bus.sclk};
            copi_sync   <= {copi_sync[CDC_LEN-2:0], bus.copi};
            ncs_sync    <= {ncs_sync[CDC_LEN-2:0], bus.n_cs};
            sync_primed <= {sync_primed[CDC_LEN-2:0], 1'b1};
        end
    end

    assign sclk_new = sclk_sync[CDC_LEN-1];
    assign sclk_old = sclk_sync[CDC_LEN];
    assign copi_s   = copi_sync[CDC_LEN-1];
    assign ncs_s    = ncs_sync[CDC_LEN-1];
    assign sample   = SAMPLE_RISE ? (sclk_new & ~sclk_old) : (~sclk_new & sclk_old);

    // Truncating casts drop the oldest bit, so ADDR_W/DATA_W of 1 need no special case.
    assign hdr_next  = (ADDR_W + 1)'({hdr_sr, copi_s});
    assign data_next = DATA_W'({data_sr, copi_s});

    // Clean ends are an empty frame or a rise exactly on a word boundary after >=1 word.
    assign frame_bad = ((state == HDR)  && (bit_cnt != '0)) ||
                       ((state == DATA) && ((bit_cnt != '0) || !got_word)) ||
                       ((state == OVF)  && (bit_cnt != '0));

    // Shift registers carry no reset: they are always refilled before use.
    always_ff @(posedge clk) begin
        if (sample && !ncs_s && (state == HDR))
            hdr_sr <= hdr_next;
        if (sample && !ncs_s && (state == DATA))
            data_sr <= data_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_CS;
            bit_cnt      <= '0;
            word_idx     <= '0;
            got_word     <= 1'b0;
            read_write_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (ncs_s) begin
                if (state != WAIT_CS)
                    frame_err_q <= frame_bad;
                if ((state != WAIT_CS) || sync_primed[CDC_LEN-1])
                    state <= IDLE;
            end else begin
                case (state)
                    WAIT_CS: state <= WAIT_CS;
                    IDLE: begin
                        state    <= HDR;
                        bit_cnt  <= '0;
                        word_idx <= '0;
                        got_word <= 1'b0;
                    end
                    HDR: if (sample) begin
                        if (bit_cnt == HDR_LAST) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    DATA: if (sample) begin
                        if (bit_cnt == DATA_LAST) begin
                            data_q       <= data_next;
                            addr_q       <= hdr_sr[ADDR_W-1:0] + word_idx;
                            read_write_q <= hdr_sr[ADDR_W];
                            valid_q      <= 1'b1;
                            word_idx     <= word_idx + 1'b1;
                            got_word     <= 1'b1;
                            bit_cnt      <= '0;
                            if (!BURST_EN)
                                state <= OVF;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    // Excess bits only need to be noticed, so the count saturates.
                    OVF: if (sample && (bit_cnt != CNT_MAX))
                        bit_cnt <= bit_cnt + 1'b1;
                    default: state <= WAIT_CS;
                endcase
            end
        end
    end

    assign bus.read_write = read_write_q;
    assign bus.addr       = addr_q;
    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = !ncs_s && (state != WAIT_CS);
endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: six instances (four SPI modes, a narrow-address /
// wide-data variant, a non-burst variant) fed by three SPI pin groups.
module tb_spi_frame_rx;
    localparam int N = 6;
    localparam int AWS    [N] = '{7, 7, 7, 7, 4, 7};
    localparam int DWS    [N] = '{8, 8, 8, 8, 16, 8};
    localparam bit CPOLS  [N] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam bit CPHAS  [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit BURSTS [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam int GRPS   [N] = '{0, 0, 0, 0, 1, 2};

    typedef struct {
        bit              err;
        bit              rw;
        int unsigned     addr;
        longint unsigned data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic p_drv [3];
    logic copi_drv [3];
    logic ncs_drv [3];

    logic        o_valid [N];
    logic        o_err   [N];
    logic        o_busy  [N];
    logic        o_rw    [N];
    logic [14:0] o_addr  [N];
    logic [31:0] o_data  [N];

    ev_t             expq [N][$];
    bit              cur_rw   [N];
    int unsigned     cur_addr [N];
    longint unsigned cur_data [N];
    int              vcnt [N];
    int              ecnt [N];
    int              total;
    int              bad;
    bit              fbits [$];
    ev_t             cmp_e;
    bit              hit;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gi
        spi_frame_rx_if #(.ADDR_W(AWS[g]), .DATA_W(DWS[g])) bus ();
        spi_frame_rx #(
            .CDC_LEN(2), .ADDR_W(AWS[g]), .DATA_W(DWS[g]),
            .CPOL(CPOLS[g]), .CPHA(CPHAS[g]), .BURST_EN(BURSTS[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        // p_drv is 1 during the leading half of each bit; idle level is CPOL.
        assign bus.sclk   = p_drv[GRPS[g]] ^ CPOLS[g];
        assign bus.copi   = copi_drv[GRPS[g]];
        assign bus.n_cs   = ncs_drv[GRPS[g]];
        assign o_valid[g] = bus.valid;
        assign o_err[g]   = bus.frame_err;
        assign o_busy[g]  = bus.busy;
        assign o_rw[g]    = bus.read_write;
        assign o_addr[g]  = 15'(bus.addr);
        assign o_data[g]  = 32'(bus.data);
    end

    task automatic chk_eq(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected events of one frame of n bits (taken from fbits) for instance i.
    function automatic void model_frame(input int i, input int n);
        ev_t e;
        int aw, dw, hw, rest, words;
        int unsigned base;
        longint unsigned d;
        aw = AWS[i];
        dw = DWS[i];
        hw = 1 + aw;
        e.err = 1'b1; e.rw = 1'b0; e.addr = 0; e.data = 0;
        if (n == 0) return;
        if (n < hw) begin
            expq[i].push_back(e);
            return;
        end
        base = 0;
        for (int k = 1; k <= aw; k++) base = base * 2 + fbits[k];
        rest  = n - hw;
        words = rest / dw;
        if (!BURSTS[i] && words > 1) words = 1;
        for (int w = 0; w < words; w++) begin
            d = 0;
            for (int b = 0; b < dw; b++) d = d * 2 + fbits[hw + w * dw + b];
            e.err  = 1'b0;
            e.rw   = fbits[0];
            e.addr = (base + w) % (1 << aw);
            e.data = d;
            expq[i].push_back(e);
        end
        if (BURSTS[i] ? ((rest % dw != 0) || (words == 0)) : (rest != dw)) begin
            e.err = 1'b1; e.rw = 1'b0; e.addr = 0; e.data = 0;
            expq[i].push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cur_rw[i] = 1'b0; cur_addr[i] = 0; cur_data[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                chk_eq($sformatf("inst%0d valid+frame_err overlap", i), 64'(o_valid[i] & o_err[i]), 0);
                if (o_valid[i]) begin
                    vcnt[i]++;
                    hit = (expq[i].size() > 0) && !expq[i][0].err;
                    if (hit) begin
                        cmp_e = expq[i].pop_front();
                        cur_rw[i] = cmp_e.rw; cur_addr[i] = cmp_e.addr; cur_data[i] = cmp_e.data;
                    end
                    chk_eq($sformatf("inst%0d valid expected", i), 64'(hit), 1);
                end
                if (o_err[i]) begin
                    ecnt[i]++;
                    hit = (expq[i].size() > 0) && expq[i][0].err;
                    if (hit) cmp_e = expq[i].pop_front();
                    chk_eq($sformatf("inst%0d frame_err expected", i), 64'(hit), 1);
                end
                chk_eq($sformatf("inst%0d read_write", i), 64'(o_rw[i]), 64'(cur_rw[i]));
                chk_eq($sformatf("inst%0d addr", i), 64'(o_addr[i]), 64'(cur_addr[i]));
                chk_eq($sformatf("inst%0d data", i), 64'(o_data[i]), cur_data[i]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input longint unsigned v, input int w);
        for (int k = w - 1; k >= 0; k--) fbits.push_back(v[k]);
    endtask

    task automatic drive_bits(input int g, input int from, input int to);
        for (int k = from; k < to; k++) begin
            copi_drv[g] = fbits[k];
            tick(4);
            p_drv[g] = 1'b1;
            tick(4);
            p_drv[g] = 1'b0;
            tick(4);
        end
    endtask

    task automatic model_group(input int g, input int n);
        for (int i = 0; i < N; i++) if (GRPS[i] == g) model_frame(i, n);
    endtask

    task automatic send(input int g, input int n);
        model_group(g, n);
        ncs_drv[g] = 1'b0;
        tick(4);
        drive_bits(g, 0, n);
        ncs_drv[g] = 1'b1;
        tick(12);
    endtask

    task automatic lit(input int i, input string what, input longint unsigned act, input longint unsigned exp);
        chk_eq($sformatf("inst%0d %s", i, what), act, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int g = 0; g < 3; g++) begin
            p_drv[g] = 1'b0; copi_drv[g] = 1'b0; ncs_drv[g] = 1'b1;
        end
        tick(5);
        rst = 1'b0;
        tick(5);
        for (int i = 0; i < N; i++) begin
            lit(i, "reset valid", 64'(o_valid[i]), 0);
            lit(i, "reset frame_err", 64'(o_err[i]), 0);
            lit(i, "reset busy", 64'(o_busy[i]), 0);
            lit(i, "reset read_write", 64'(o_rw[i]), 0);
            lit(i, "reset addr", 64'(o_addr[i]), 0);
            lit(i, "reset data", 64'(o_data[i]), 0);
        end

        // Single word, all four modes.
        fbits.delete(); put(1, 1); put('h15, 7); put('hA5, 8);
        model_group(0, 16);
        ncs_drv[0] = 1'b0;
        tick(4);
        drive_bits(0, 0, 8);
        for (int i = 0; i < 4; i++) lit(i, "busy mid-frame", 64'(o_busy[i]), 1);
        drive_bits(0, 8, 16);
        ncs_drv[0] = 1'b1;
        tick(12);
        for (int i = 0; i < 4; i++) begin
            lit(i, "t1 read_write", 64'(o_rw[i]), 1);
            lit(i, "t1 addr", 64'(o_addr[i]), 'h15);
            lit(i, "t1 data", 64'(o_data[i]), 'hA5);
            lit(i, "t1 valid count", 64'(vcnt[i]), 1);
            lit(i, "t1 frame_err count", 64'(ecnt[i]), 0);
        end

        // Abort mid data word: 8 header bits plus 4 data bits.
        send(0, 12);
        for (int i = 0; i < 4; i++) begin
            lit(i, "abort frame_err count", 64'(ecnt[i]), 1);
            lit(i, "abort valid count", 64'(vcnt[i]), 1);
            lit(i, "abort addr held", 64'(o_addr[i]), 'h15);
            lit(i, "abort data held", 64'(o_data[i]), 'hA5);
        end

        // Burst with address wrap.
        fbits.delete(); put(1, 1); put('h7F, 7); put('h11, 8); put('h22, 8); put('h33, 8);
        send(0, 32);
        for (int i = 0; i < 4; i++) begin
            lit(i, "burst valid count", 64'(vcnt[i]), 4);
            lit(i, "burst last addr", 64'(o_addr[i]), 'h01);
            lit(i, "burst last data", 64'(o_data[i]), 'h33);
            lit(i, "burst frame_err count", 64'(ecnt[i]), 1);
        end

        // Narrow address / wide data instance.
        fbits.delete(); put(1, 1); put('h5, 4); put('hA5, 16);
        send(1, 21);
        lit(4, "w16 read_write", 64'(o_rw[4]), 1);
        lit(4, "w16 addr", 64'(o_addr[4]), 'h5);
        lit(4, "w16 data", 64'(o_data[4]), 'hA5);
        lit(4, "w16 frame_err count", 64'(ecnt[4]), 0);

        // Reset in the middle of a frame; the rest of that frame must be ignored.
        fbits.delete(); put(1, 1); put('h2A, 7); put('h77, 8);
        ncs_drv[0] = 1'b0;
        tick(4);
        drive_bits(0, 0, 10);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        for (int k = 10; k < 16; k++) begin
            drive_bits(0, k, k + 1);
            for (int i = 0; i < 4; i++) lit(i, "busy after reset", 64'(o_busy[i]), 0);
        end
        ncs_drv[0] = 1'b1;
        tick(12);
        for (int i = 0; i < 4; i++) begin
            lit(i, "post-reset valid count", 64'(vcnt[i]), 4);
            lit(i, "post-reset frame_err count", 64'(ecnt[i]), 1);
            lit(i, "post-reset data", 64'(o_data[i]), 0);
        end
        fbits.delete(); put(0, 1); put('h01, 7); put('h3C, 8);
        send(0, 16);
        for (int i = 0; i < 4; i++) begin
            lit(i, "clean read_write", 64'(o_rw[i]), 0);
            lit(i, "clean addr", 64'(o_addr[i]), 'h01);
            lit(i, "clean data", 64'(o_data[i]), 'h3C);
        end

        // Non-burst instance with three words' worth of data bits.
        fbits.delete(); put(1, 1); put('h15, 7); put('hA5, 8); put('h5A, 8); put('hFF, 8);
        send(2, 32);
        lit(5, "single valid count", 64'(vcnt[5]), 1);
        lit(5, "single frame_err count", 64'(ecnt[5]), 1);
        lit(5, "single data", 64'(o_data[5]), 'hA5);
        lit(5, "single addr", 64'(o_addr[5]), 'h15);

        tick(10);
        for (int i = 0; i < N; i++) lit(i, "outstanding expected events", 64'(expq[i].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
